// File: rtl/mac_feeder.sv
// mac_feeder: sequences A-row/B-column term pairs into a signed 8-bit MAC and
// writes each 32-bit dot product to C memory in row-major order.
`default_nettype none

module mac_feeder #(
  parameter int DIM_W   = 4,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                start_i,
  input  logic [DIM_W-1:0]    dim_m_i,
  input  logic [DIM_W-1:0]    dim_k_i,
  input  logic [DIM_W-1:0]    dim_n_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                a_rd_o,
  output logic [ADDR_W-1:0]   a_addr_o,
  input  logic signed [7:0]   a_data_i,
  output logic                b_rd_o,
  output logic [ADDR_W-1:0]   b_addr_o,
  input  logic signed [7:0]   b_data_i,
  output logic                dsp_enable_o,
  output logic                clear_o,
  output logic                dsp_valid_o,
  output logic signed [7:0]   dsp_input_o,
  output logic signed [7:0]   dsp_weight_o,
  input  logic signed [31:0]  dsp_output_i,
  input  logic                dsp_valid_i,
  output logic                c_we_o,
  output logic [ADDR_W-1:0]   c_addr_o,
  output logic signed [31:0]  c_data_o
);

  localparam int PROD_W = 2 * DIM_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_TAIL  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   dim_m_q, dim_m_d;
  logic [DIM_W-1:0]   dim_k_q, dim_k_d;
  logic [DIM_W-1:0]   dim_n_q, dim_n_d;
  logic [DIM_W-1:0]   i_q, i_d;
  logic [DIM_W-1:0]   j_q, j_d;
  logic [DIM_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               err_q, err_d;
  logic               tmo_q, tmo_d;
  logic               term_q, term_d;

  logic [PROD_W-1:0]  a_prod, b_prod, c_prod;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      dim_m_q    <= '0;
      dim_k_q    <= '0;
      dim_n_q    <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      term_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dim_m_q    <= dim_m_d;
      dim_k_q    <= dim_k_d;
      dim_n_q    <= dim_n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      term_q     <= term_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dim_m_d    = dim_m_q;
    dim_k_d    = dim_k_q;
    dim_n_d    = dim_n_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    // Memory data for a FEED read appears on the following cycle.
    term_d     = (state_q == S_FEED);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dim_m_d = dim_m_i;
          dim_k_d = dim_k_i;
          dim_n_d = dim_n_i;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          if (dim_m_i == '0 || dim_k_i == '0 || dim_n_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FEED;
          end
        end
      end
      S_FEED: begin
        if (k_q == dim_k_q - DIM_W'(1)) begin
          state_d = S_TAIL;
        end else begin
          k_d = k_q + DIM_W'(1);
        end
      end
      S_TAIL: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (dsp_valid_i) begin
          tmo_d   = 1'b0;
          state_d = S_WRITE;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_WRITE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        k_d   = '0;
        tmo_d = 1'b0;
        if (j_q == dim_n_q - DIM_W'(1)) begin
          j_d = '0;
          if (i_q == dim_m_q - DIM_W'(1)) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + DIM_W'(1);
            state_d = S_FEED;
          end
        end else begin
          j_d     = j_q + DIM_W'(1);
          state_d = S_FEED;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign a_prod = PROD_W'(i_q) * PROD_W'(dim_k_q) + PROD_W'(k_q);
  assign b_prod = PROD_W'(k_q) * PROD_W'(dim_n_q) + PROD_W'(j_q);
  assign c_prod = PROD_W'(i_q) * PROD_W'(dim_n_q) + PROD_W'(j_q);

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = err_q;
  assign dsp_enable_o = busy_o;

  assign a_rd_o       = (state_q == S_FEED);
  assign b_rd_o       = (state_q == S_FEED);
  assign a_addr_o     = a_rd_o ? ADDR_W'(a_prod) : '0;
  assign b_addr_o     = b_rd_o ? ADDR_W'(b_prod) : '0;
  assign clear_o      = (state_q == S_FEED) && (k_q == '0);
  assign dsp_valid_o  = (state_q == S_TAIL);
  assign dsp_input_o  = term_q ? a_data_i : 8'sd0;
  assign dsp_weight_o = term_q ? b_data_i : 8'sd0;

  assign c_we_o       = (state_q == S_WRITE);
  assign c_addr_o     = c_we_o ? ADDR_W'(c_prod) : '0;
  assign c_data_o     = (c_we_o && !tmo_q) ? dsp_output_i : 32'sd0;

endmodule

`default_nettype wire

// File: tb/tb_mac_feeder.sv
// Testbench for mac_feeder: memory and MAC models around the DUT, results
// compared with a plain matrix-product reference and the cycle timing rules.
`timescale 1ns/1ps
`default_nettype none

module tb_mac_feeder;
  localparam int DIM_W   = 4;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int BUDGET  = 3000;

  logic clk = 1'b0;
  logic rstn_i = 1'b0;
  logic start_i = 1'b0;
  logic [DIM_W-1:0] dim_m_i = '0, dim_k_i = '0, dim_n_i = '0;
  logic busy_o, done_o, err_o, a_rd_o, b_rd_o, dsp_enable_o, clear_o, dsp_valid_o, c_we_o;
  logic [ADDR_W-1:0] a_addr_o, b_addr_o, c_addr_o;
  logic signed [7:0] a_data_i = '0, b_data_i = '0, dsp_input_o, dsp_weight_o;
  logic signed [31:0] dsp_output_i, c_data_o;
  logic dsp_valid_i;

  mac_feeder #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i),
    .dim_m_i(dim_m_i), .dim_k_i(dim_k_i), .dim_n_i(dim_n_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .a_rd_o(a_rd_o), .a_addr_o(a_addr_o), .a_data_i(a_data_i),
    .b_rd_o(b_rd_o), .b_addr_o(b_addr_o), .b_data_i(b_data_i),
    .dsp_enable_o(dsp_enable_o), .clear_o(clear_o), .dsp_valid_o(dsp_valid_o),
    .dsp_input_o(dsp_input_o), .dsp_weight_o(dsp_weight_o),
    .dsp_output_i(dsp_output_i), .dsp_valid_i(dsp_valid_i),
    .c_we_o(c_we_o), .c_addr_o(c_addr_o), .c_data_o(c_data_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int s0 = 0;
  int lat = 2;
  bit mac_en = 1'b1;

  // Synchronous-read memories
  logic signed [7:0] amem [256];
  logic signed [7:0] bmem [256];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_rd_o) a_data_i <= amem[a_addr_o];
    if (b_rd_o) b_data_i <= bmem[b_addr_o];
  end

  // MAC model: accumulate terms, present result lat cycles after dsp_valid_o
  int acc = 0, res = 0, acc_nx;
  logic [7:0] vp = '0;
  always_comb acc_nx = (clear_o ? 0 : acc) + int'(dsp_input_o) * int'(dsp_weight_o);
  always @(posedge clk) begin
    if (!rstn_i) vp <= '0;
    else vp <= {vp[6:0], dsp_valid_o & mac_en};
    if (dsp_enable_o) begin
      acc <= acc_nx;
      if (dsp_valid_o) res <= acc_nx;
    end
  end
  assign dsp_valid_i  = vp[lat-1];
  assign dsp_output_i = res;

  // Monitor of observable events
  typedef struct { int cyc; int addr; int data; } wr_t;
  wr_t wq[$];
  int n_done = 0, last_done = 0, n_clear = 0, last_clear = 0;
  int n_valid = 0, last_valid = 0, n_rd = 0;
  always @(negedge clk) begin
    if (c_we_o) wq.push_back('{cyc, int'(c_addr_o), int'(c_data_o)});
    if (done_o) begin n_done <= n_done + 1; last_done <= cyc; end
    if (clear_o) begin n_clear <= n_clear + 1; last_clear <= cyc; end
    if (dsp_valid_o) begin n_valid <= n_valid + 1; last_valid <= cyc; end
    if (a_rd_o || b_rd_o) n_rd <= n_rd + 1;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] outs();
    return {busy_o, done_o, err_o, a_rd_o, a_addr_o, b_rd_o, b_addr_o, dsp_enable_o,
            clear_o, dsp_valid_o, dsp_input_o, dsp_weight_o, c_we_o, c_addr_o, c_data_o};
  endfunction

  task automatic fill_rand();
    for (int a = 0; a < 256; a++) begin
      amem[a] = 8'($urandom);
      bmem[a] = 8'($urandom);
    end
  endtask

  int wb, nc0, nv0, nr0;

  task automatic run(input int m, input int k, input int n, input int l, input bit en,
                     input int poke, output int rel_done);
    int nd0, waited;
    lat = l;
    mac_en = en;
    @(negedge clk);
    #1;
    wb = wq.size(); nd0 = n_done; nc0 = n_clear; nv0 = n_valid; nr0 = n_rd;
    start_i = 1'b1;
    dim_m_i = DIM_W'(m); dim_k_i = DIM_W'(k); dim_n_i = DIM_W'(n);
    s0 = cyc;
    @(negedge clk);
    #1;
    start_i = 1'b0;
    chk("err_clr_on_start", err_o, 0);
    waited = 0;
    while (n_done == nd0 && waited < BUDGET) begin
      if (poke >= 0 && cyc - s0 == poke) begin
        start_i = 1'b1; dim_m_i = 1; dim_k_i = 1; dim_n_i = 1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      #1;
      waited++;
    end
    start_i = 1'b0;
    if (n_done == nd0) begin
      chk("done_seen", 0, 1);
      rel_done = -1;
    end else begin
      rel_done = last_done - s0;
    end
  endtask

  task automatic check_run(input int m, input int k, input int n, input int l, input bit en,
                           input int rel_done);
    int ne, per, got, c, i, j;
    ne  = (m == 0 || k == 0 || n == 0) ? 0 : m * n;
    per = en ? k + l + 2 : k + TIMEOUT + 2;
    got = wq.size() - wb;
    chk("n_writes", got, ne);
    chk("done_cyc", rel_done, ne == 0 ? 1 : 1 + ne * per);
    for (int e = 0; e < ne && e < got; e++) begin
      i = e / n;
      j = e % n;
      c = 0;
      if (en) for (int kk = 0; kk < k; kk++) c += int'(amem[i*k+kk]) * int'(bmem[kk*n+j]);
      chk("wr_addr", wq[wb+e].addr, e);
      chk("wr_data", wq[wb+e].data, c);
      chk("wr_cyc", wq[wb+e].cyc - s0, 1 + e * per + k + (en ? l : TIMEOUT) + 1);
    end
    chk("err_end", err_o, (!en && ne > 0) ? 1 : 0);
  endtask

  typedef struct { int m; int k; int n; int l; bit en; int exp_done; } vec_t;
  vec_t tbl[8];
  int rd, m, k, n, l;

  initial begin
    tbl[0] = '{2, 2, 2, 2, 1'b1, 25};
    tbl[1] = '{1, 1, 1, 2, 1'b1, 6};
    tbl[2] = '{3, 2, 1, 1, 1'b1, 16};
    tbl[3] = '{1, 3, 2, 3, 1'b1, 17};
    tbl[4] = '{2, 0, 3, 2, 1'b1, 1};
    tbl[5] = '{0, 4, 4, 2, 1'b1, 1};
    tbl[6] = '{1, 2, 1, 2, 1'b0, 21};
    tbl[7] = '{2, 1, 2, 4, 1'b1, 29};

    // Reset state
    #12;
    chk("outs_in_reset", outs(), 0);
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    #1;
    chk("outs_idle", outs(), 0);

    // 2x2x2 known matrices
    fill_rand();
    amem[0] = 1; amem[1] = 2; amem[2] = 3; amem[3] = 4;
    bmem[0] = 5; bmem[1] = 6; bmem[2] = 7; bmem[3] = 8;
    run(2, 2, 2, 2, 1'b1, -1, rd);
    check_run(2, 2, 2, 2, 1'b1, rd);
    if (wq.size() - wb == 4) begin
      chk("c00", wq[wb].data, 19);
      chk("c01", wq[wb+1].data, 22);
      chk("c10", wq[wb+2].data, 43);
      chk("c11", wq[wb+3].data, 50);
      chk("c11_cyc", wq[wb+3].cyc - s0, 24);
    end else begin
      chk("known_write_count", wq.size() - wb, 4);
    end
    chk("known_done", rd, 25);

    // K=15, all -128
    for (int a = 0; a < 256; a++) begin amem[a] = -8'sd128; bmem[a] = -8'sd128; end
    run(1, 15, 1, 2, 1'b1, -1, rd);
    check_run(1, 15, 1, 2, 1'b1, rd);
    if (wq.size() > wb) chk("k15_data", wq[wb].data, 245760);
    chk("k15_clear_count", n_clear - nc0, 1);
    chk("k15_valid_count", n_valid - nv0, 1);
    chk("k15_valid_minus_clear", last_valid - last_clear, 15);

    // Zero dimension
    run(3, 0, 2, 2, 1'b1, -1, rd);
    check_run(3, 0, 2, 2, 1'b1, rd);
    chk("zero_dim_reads", n_rd - nr0, 0);

    // MAC never responds: timeout
    fill_rand();
    run(1, 1, 1, 2, 1'b0, -1, rd);
    check_run(1, 1, 1, 2, 1'b0, rd);
    repeat (5) @(negedge clk);
    chk("err_sticky", err_o, 1);

    // start pulsed mid-operation is ignored
    run(2, 2, 2, 2, 1'b1, 8, rd);
    check_run(2, 2, 2, 2, 1'b1, rd);

    // Asynchronous reset during the second WAIT
    fill_rand();
    lat = 2; mac_en = 1'b1;
    @(negedge clk);
    start_i = 1'b1; dim_m_i = 2; dim_k_i = 2; dim_n_i = 2;
    s0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc - s0 < 10) @(negedge clk);
    chk("busy_before_rst", busy_o, 1);
    #2 rstn_i = 1'b0;
    #1 chk("outs_async_rst", outs(), 0);
    @(negedge clk);
    rstn_i = 1'b1;
    run(2, 2, 2, 2, 1'b1, -1, rd);
    check_run(2, 2, 2, 2, 1'b1, rd);

    // Table of directed cases
    for (int t = 0; t < 8; t++) begin
      fill_rand();
      run(tbl[t].m, tbl[t].k, tbl[t].n, tbl[t].l, tbl[t].en, -1, rd);
      check_run(tbl[t].m, tbl[t].k, tbl[t].n, tbl[t].l, tbl[t].en, rd);
      chk("tbl_done", rd, tbl[t].exp_done);
    end

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      fill_rand();
      m = $urandom_range(0, 4);
      k = $urandom_range(0, 5);
      n = $urandom_range(0, 4);
      l = $urandom_range(1, 4);
      run(m, k, n, l, 1'b1, -1, rd);
      check_run(m, k, n, l, 1'b1, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_feeder.md
# mac_feeder

Sequencer that drives a single 8-bit signed MAC unit to compute C = A × B for small matrices held in external synchronous-read memories. It fetches one A-row/B-column term pair per cycle and presents it to the MAC with a clear at the start and a valid on the last term of each dot product. It waits for the MAC result handshake and writes each 32-bit result to the C memory in row-major order. It sits between the matrix buffers and the MAC datapath in the matrix-multiplier top level.

## Interface
- DIM_W, 4: width of each dimension input; max dimension 2^DIM_W−1.
- ADDR_W, 8: memory address width; must be ≥ 2·DIM_W. Addresses are truncated to ADDR_W.
- TIMEOUT, 16: max cycles to wait for the MAC result valid.

- clk_i  in  1  clock; all logic is rising-edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  start pulse; ignored while busy_o=1.
- dim_m_i, dim_k_i, dim_n_i  in  DIM_W each  M, K, N; latched on an accepted start.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle pulse at the end of an operation.
- err_o  out  1  sticky MAC-timeout flag; cleared on an accepted start.
- a_rd_o, a_addr_o  out  1, ADDR_W  A read strobe and address; data returns 1 cycle later.
- a_data_i  in  8  A read data, signed.
- b_rd_o, b_addr_o  out  1, ADDR_W  B read strobe and address; data returns 1 cycle later.
- b_data_i  in  8  B read data, signed.
- dsp_enable_o  out  1  MAC clock enable.
- clear_o  out  1  MAC accumulator clear.
- dsp_valid_o  out  1  marks the last term of a dot product.
- dsp_input_o, dsp_weight_o  out  8 each  term operands, signed.
- dsp_output_i  in  32  MAC result, signed.
- dsp_valid_i  in  1  MAC result valid.
- c_we_o, c_addr_o, c_data_o  out  1, ADDR_W, 32  C write port.

## Operation
- States: IDLE, FEED, TAIL, WAIT, WRITE, DONE.
- IDLE → FEED on start_i. Dimensions are latched and err_o is cleared. Indices are set to i=j=k=0.
- If any of M, K or N is 0, go IDLE → DONE instead. No reads or writes are issued.
- FEED runs for K cycles, k = 0..K−1:
  - a_rd_o=b_rd_o=1.
  - a_addr_o = i·K+k; b_addr_o = k·N+j.
  - clear_o=1 only when k=0.
  - On k=K−1 go to TAIL.
- Term presentation:
  - In the cycle after each FEED cycle, dsp_input_o=a_data_i and dsp_weight_o=b_data_i, passed through combinationally from the memory output.
  - In all other cycles both operands are 0.
- dsp_valid_o=1 in TAIL only. TAIL is the cycle that presents term K−1. TAIL → WAIT.
- WAIT:
  - On dsp_valid_i=1, go to WRITE.
  - If the wait counter reaches TIMEOUT cycles after TAIL, set err_o=1 and go to WRITE with result 0.
  - A dsp_valid_i seen outside WAIT is ignored.
- WRITE:
  - c_we_o=1, c_addr_o = i·N+j, c_data_o = dsp_output_i sampled in this cycle (or 0 after a timeout).
  - Then advance j; on j wrap advance i.
  - Next state is FEED, or DONE after element (M−1, N−1).
- DONE: done_o=1 for one cycle, then IDLE.
- dsp_enable_o = busy_o.
- busy_o=1 in every state except IDLE.
- Arithmetic: the feeder computes no data. Address products use 2·DIM_W-bit unsigned math, then truncate to ADDR_W.
- Asynchronous reset at any time: state → IDLE. All outputs are 0 and err_o=0. An operation in progress is abandoned and not resumed.

## Timing
- Every output resets to 0.
- start_i is accepted in cycle 0. The first FEED cycle is F0 = cycle 1.
- For each element, with MAC latency L (cycles from dsp_valid_o to dsp_valid_i):
  - FEED: F0 .. F0+K−1.
  - TAIL: F0+K.
  - dsp_valid_i: F0+K+L.
  - WRITE: F0+K+L+1.
  - Next element F0: F0+K+L+2.
- Per-element period is K+L+2 cycles. For the team MAC, L=2, giving K+4.
- done_o is asserted the cycle after the final WRITE. busy_o falls the cycle after done_o.

## Test plan
- M=K=N=2, A=[1,2;3,4], B=[5,6;7,8], MAC model L=2 → C writes 19, 22, 43, 50 to addresses 0..3. Writes occur at cycles 6, 12, 18, 24; done_o at 25; err_o=0.
- M=N=1, K=15, all A=B=−128 → single write c_addr=0, c_data=245760. clear_o is high exactly once; dsp_valid_o is high exactly once, 15 cycles after clear_o.
- dim_k_i=0 with start → done_o at cycle 1. No a_rd_o, b_rd_o or c_we_o activity.
- MAC model never asserts dsp_valid_i, M=K=N=1 → err_o=1 and c_data_o=0 written at TAIL+17. err_o stays 1 until the next start.
- start_i pulsed again mid-operation with different dimensions → ignored; results match the original dimensions.
- rstn_i low during the second WAIT of a 2×2×2 run → all outputs 0 immediately. After release and a new start, the full correct result is produced.
